// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and types for the N-by-W registered mux
package mux_pkg;

    localparam int W_DEF = 32;
    localparam int N_DEF = 4;
    localparam int CNT_W = 16;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/mux_nxw_reg_if.sv
// rtl/mux_nxw_reg_if.sv - channel inputs, output beat and select controls of mux_nxw_reg
interface mux_nxw_reg_if
    import mux_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic              mode;
    logic [SW-1:0]     sel;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_ch;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - round-robin picker: first valid channel at or after ptr, wrapping mod N
module rr_grant #(
    parameter int N  = 4,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt,
    output logic          gnt_vld
);
    logic [2*N-1:0] rot;
    logic [SW:0]    sum;

    // Rotate so bit 0 is the ptr channel; descending scan lets the lowest offset win.
    always_comb begin
        rot     = {valid, valid} >> ptr;
        gnt     = '0;
        gnt_vld = 1'b0;
        sum     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr} + (SW+1)'(i);
                if (sum >= (SW+1)'(N)) begin
                    sum = sum - (SW+1)'(N);
                end
                gnt     = sum[SW-1:0];
                gnt_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_nxw_reg.sv
// rtl/mux_nxw_reg.sv - N-channel W-bit mux with direct/round-robin grant and one-entry output register
// Optional per-channel accept counters when MUX_NXW_REG_CNT_EN is defined.
module mux_nxw_reg
    import mux_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_nxw_reg_if.slave         bus
`ifdef MUX_NXW_REG_CNT_EN
    ,
    output logic [N*CNT_W-1:0]   grant_cnt
`endif
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    state_t        state_q, state_d;
    logic [SW-1:0] ptr;
    logic [SW-1:0] rr_gnt, gnt;
    logic          rr_vld, dir_vld, gnt_vld;
    logic [N-1:0]  vld_sh;
    logic          open_reg, accept;
    logic [W-1:0]  gnt_data;
    logic [W-1:0]  data_q;
    logic [SW-1:0] ch_q;

    rr_grant #(.N(N), .SW(SW)) u_rr_grant (
        .valid   (bus.in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_vld (rr_vld)
    );

    // sel may exceed N-1 when N is not a power of two; such indices never grant.
    assign vld_sh  = bus.in_valid >> bus.sel;
    assign dir_vld = ({1'b0, bus.sel} < (SW+1)'(N)) && vld_sh[0];

    assign gnt      = (bus.mode == MODE_RR) ? rr_gnt : bus.sel;
    assign gnt_vld  = (bus.mode == MODE_RR) ? rr_vld : dir_vld;
    assign open_reg = (state_q == ST_EMPTY) || bus.out_ready;
    assign accept   = open_reg && gnt_vld && !rst;

    always_comb begin
        bus.in_ready = '0;
        gnt_data     = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt == SW'(k)) begin
                bus.in_ready[k] = accept;
                gnt_data        = bus.in_data[k*W +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_FULL;
        end else if (state_q == ST_FULL && bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= gnt_data;
                ch_q   <= gnt;
                if (bus.mode == MODE_RR) begin
                    ptr <= (gnt == SW'(N - 1)) ? '0 : gnt + SW'(1);
                end
            end
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;

`ifdef MUX_NXW_REG_CNT_EN
    logic [CNT_W-1:0] cnt [N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (accept && gnt == SW'(k) && cnt[k] != '1) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int k = 0; k < N; k++) begin
            grant_cnt[k*CNT_W +: CNT_W] = cnt[k];
        end
    end
`endif
endmodule

// File: tb/tb_mux_nxw_reg.sv
// tb/tb_mux_nxw_reg.sv - directed self-checking bench for mux_nxw_reg (N=4/W=32 and N=3/W=8)
module tb_mux_nxw_reg;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mux_nxw_reg_if #(.W(32), .N(4)) bus4 ();
    mux_nxw_reg_if #(.W(8),  .N(3)) bus3 ();

`ifdef MUX_NXW_REG_CNT_EN
    logic [4*16-1:0] cnt4;
    logic [3*16-1:0] cnt3;
`endif

    mux_nxw_reg #(.W(32), .N(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus4)
`ifdef MUX_NXW_REG_CNT_EN
        ,
        .grant_cnt (cnt4)
`endif
    );

    mux_nxw_reg #(.W(8), .N(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus3)
`ifdef MUX_NXW_REG_CNT_EN
        ,
        .grant_cnt (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rr_exp [6];
        rr_exp = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        tests = 0;
        fails = 0;

        // Reset with every channel valid: nothing may see ready.
        rst = 1'b1;
        bus4.mode = 1'b1; bus4.sel = 2'd0; bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
        bus4.in_data = {32'd4, 32'd3, 32'd2, 32'd1};
        bus3.mode = 1'b0; bus3.sel = 2'd0; bus3.in_valid = 3'b000; bus3.out_ready = 1'b1;
        bus3.in_data = {8'hC3, 8'hB2, 8'hA1};
        #2;
        chk("rst_in_ready", 64'(bus4.in_ready), 64'h0);
        tick();
        chk("rst_out_valid", 64'(bus4.out_valid), 64'h0);
        chk("rst_out_data", 64'(bus4.out_data), 64'h0);
        chk("rst_out_ch", 64'(bus4.out_ch), 64'h0);
        chk("rst_ptr", 64'(dut4.ptr), 64'h0);
        rst = 1'b0;

        // Direct select of channel 2.
        bus4.mode = 1'b0; bus4.sel = 2'd2;
        #1;
        chk("dir_in_ready", 64'(bus4.in_ready), 64'h4);
        tick();
        chk("dir_out_valid", 64'(bus4.out_valid), 64'h1);
        chk("dir_out_data", 64'(bus4.out_data), 64'd3);
        chk("dir_out_ch", 64'(bus4.out_ch), 64'd2);
        chk("dir_ptr", 64'(dut4.ptr), 64'h0);

        // Round-robin over channels 0,1,3 at one beat per cycle.
        bus4.mode = 1'b1; bus4.in_valid = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_in_ready", 64'(bus4.in_ready), 64'(4'b0001 << rr_exp[i]));
            tick();
            chk("rr_out_ch", 64'(bus4.out_ch), 64'(rr_exp[i]));
            chk("rr_out_data", 64'(bus4.out_data), 64'(rr_exp[i]) + 64'd1);
            chk("rr_out_valid", 64'(bus4.out_valid), 64'h1);
        end
        chk("rr_ptr_wrap", 64'(dut4.ptr), 64'h0);

        // Backpressure: hold beat 1 for 5 cycles, then drain and refill on the same edge.
        bus4.in_valid = 4'b0001;
        tick();
        chk("bp_load_data", 64'(bus4.out_data), 64'd1);
        chk("bp_ptr", 64'(dut4.ptr), 64'h1);
        bus4.out_ready = 1'b0;
        bus4.in_data[31:0] = 32'd9;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 64'(bus4.in_ready), 64'h0);
            tick();
            chk("bp_hold_data", 64'(bus4.out_data), 64'd1);
            chk("bp_hold_ch", 64'(bus4.out_ch), 64'd0);
            chk("bp_hold_valid", 64'(bus4.out_valid), 64'h1);
        end
        bus4.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus4.in_ready), 64'h1);
        tick();
        chk("bp_refill_data", 64'(bus4.out_data), 64'd9);
        chk("bp_refill_valid", 64'(bus4.out_valid), 64'h1);
        bus4.in_valid = 4'b0000;
        tick();
        chk("bp_drain_valid", 64'(bus4.out_valid), 64'h0);

        // Asynchronous reset while FULL and stalled, with ptr nonzero.
        bus4.mode = 1'b0; bus4.sel = 2'd2; bus4.in_valid = 4'b0100;
        tick();
        chk("ar_full_ch", 64'(bus4.out_ch), 64'd2);
        bus4.out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", 64'(bus4.out_valid), 64'h0);
        chk("ar_out_ch", 64'(bus4.out_ch), 64'h0);
        chk("ar_out_data", 64'(bus4.out_data), 64'h0);
        chk("ar_ptr", 64'(dut4.ptr), 64'h0);
        chk("ar_in_ready", 64'(bus4.in_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        bus4.mode = 1'b1; bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
        #1;
        chk("ar_post_ready", 64'(bus4.in_ready), 64'h1);
        tick();
        chk("ar_post_ch", 64'(bus4.out_ch), 64'h0);
        bus4.in_valid = 4'b0000;

        // N=3: out-of-range select never grants; rr grant at ch2 wraps ptr.
        bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_valid = 3'b111;
        #1;
        chk("n3_sel3_ready", 64'(bus3.in_ready), 64'h0);
        tick();
        tick();
        chk("n3_sel3_valid", 64'(bus3.out_valid), 64'h0);
        bus3.mode = 1'b1; bus3.in_valid = 3'b001;
        tick();
        chk("n3_ch0", 64'(bus3.out_ch), 64'd0);
        chk("n3_ptr1", 64'(dut3.ptr), 64'd1);
        bus3.in_valid = 3'b100;
        #1;
        chk("n3_ready_ch2", 64'(bus3.in_ready), 64'h4);
        tick();
        chk("n3_ch2", 64'(bus3.out_ch), 64'd2);
        chk("n3_data_ch2", 64'(bus3.out_data), 64'hC3);
        chk("n3_ptr_wrap", 64'(dut3.ptr), 64'd0);
        bus3.in_valid = 3'b000;

`ifdef MUX_NXW_REG_CNT_EN
        // Counter saturation on ch1 only.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus4.mode = 1'b0; bus4.sel = 2'd1; bus4.in_valid = 4'b0010; bus4.out_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        bus4.in_valid = 4'b0000;
        chk("cnt_ch0", 64'(cnt4[15:0]), 64'h0);
        chk("cnt_ch1", 64'(cnt4[31:16]), 64'hFFFF);
        chk("cnt_ch2", 64'(cnt4[47:32]), 64'h0);
        chk("cnt_ch3", 64'(cnt4[63:48]), 64'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
